exe_stage: RTL and testbench

//   Execute stage of the 16-bit five-stage pipeline. Sits between the ID/EX operands (A, B, Immediate1) and the MEM stage.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/exe_stage_if.sv | 26 ++
 rtl/exe_stage_alu.sv | 27 ++
 rtl/exe_stage.sv | 47 ++++
 tb/tb_exe_stage.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_pkg : shared ALU opcodes, EX control field layout, datapath width |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package pipe_pkg;
    localparam int DATA_W = 16;

    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam int EX_ALUSRC   = 2;
    localparam int EX_ALUOP_HI = 1;
    localparam int EX_ALUOP_LO = 0;
endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exe_stage_if : ID/EX operands in, EX/MEM registered results out        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface exe_stage_if;
    import pipe_pkg::*;

    logic [DATA_W-1:0] Immediate1;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        signals;
    logic [DATA_W-1:0] AluResult;
    logic [DATA_W-1:0] DataMemory;

    modport master (
        output Immediate1, A, B, signals,
        input  AluResult, DataMemory
    );

    modport slave (
        input  Immediate1, A, B, signals,
        output AluResult, DataMemory
    );
endinterface
`default_nettype wire

// File: rtl/exe_stage_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu : combinational AND / ADD / SUB / PASS, results wrap modulo 2^W    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module alu
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [1:0]       op,
    output logic      [WIDTH-1:0] result
);
    always_comb begin
        result = '0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_PASS: result = b;
            default:  result = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exe_stage : operand select, ALU, and EX/MEM output registers           |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module exe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  wire logic clk,
    input  wire logic rst_n,
    exe_stage_if.slave bus
);
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_result;
    logic [1:0]       w_alu_op;
    logic [WIDTH-1:0] r_alu_result;
    logic [WIDTH-1:0] r_data_memory;

    assign w_op_b   = bus.signals[EX_ALUSRC] ? bus.Immediate1 : bus.B;
    assign w_alu_op = bus.signals[EX_ALUOP_HI:EX_ALUOP_LO];

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (bus.A),
        .b      (w_op_b),
        .op     (w_alu_op),
        .result (w_alu_result)
    );

    // Store data is always the raw register operand, never the immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result  <= '0;
            r_data_memory <= '0;
        end else begin
            r_alu_result  <= w_alu_result;
            r_data_memory <= bus.B;
        end
    end

    assign bus.AluResult  = r_alu_result;
    assign bus.DataMemory = r_data_memory;
endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_exe_stage : directed and back-to-back checks of the execute stage   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_exe_stage;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    exe_stage_if bus ();

    exe_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] imm, input logic [2:0] sig);
        bus.A          = a;
        bus.B          = b;
        bus.Immediate1 = imm;
        bus.signals    = sig;
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic [2:0] sig);
        @(negedge clk);
        apply(a, b, imm, sig);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] imm, input logic [2:0] sig);
        logic [15:0] opb;
        opb = (sig[2] == 1'b1) ? imm : b;
        if (sig[1:0] == 2'd0)      return a & opb;
        else if (sig[1:0] == 2'd1) return 16'((32'(a) + 32'(opb)) % 32'h10000);
        else if (sig[1:0] == 2'd2) return 16'((32'(a) + 32'h10000 - 32'(opb)) % 32'h10000);
        else                       return opb;
    endfunction

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vi [8];
    logic [2:0]  vs [8];
    logic [15:0] prev_res;
    logic [15:0] prev_dm;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        apply(16'h1111, 16'h2222, 16'h3333, 3'b001);

        repeat (2) @(posedge clk);
        #1;
        check("reset_alu", bus.AluResult, 16'h0000);
        check("reset_dm", bus.DataMemory, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;

        step(16'h0005, 16'h0003, 16'h7777, 3'b001);
        check("add_reg_alu", bus.AluResult, 16'h0008);
        check("add_reg_dm", bus.DataMemory, 16'h0003);

        step(16'h0000, 16'h1234, 16'h0001, 3'b110);
        check("sub_imm_wrap_alu", bus.AluResult, 16'hFFFF);
        check("sub_imm_wrap_dm", bus.DataMemory, 16'h1234);

        step(16'hFFFF, 16'h5A5A, 16'h0001, 3'b101);
        check("add_ovf_alu", bus.AluResult, 16'h0000);
        check("add_ovf_dm", bus.DataMemory, 16'h5A5A);

        step(16'hF0F0, 16'h0FF0, 16'hFFFF, 3'b000);
        check("and_reg_alu", bus.AluResult, 16'h00F0);
        check("and_reg_dm", bus.DataMemory, 16'h0FF0);

        step(16'hF0F0, 16'h0FF0, 16'h00AB, 3'b111);
        check("pass_imm_alu", bus.AluResult, 16'h00AB);
        check("pass_imm_dm", bus.DataMemory, 16'h0FF0);

        step(16'h0010, 16'h0003, 16'h0100, 3'b010);
        check("sub_reg_alu", bus.AluResult, 16'h000D);

        step(16'hAAAA, 16'h0042, 16'hBEEF, 3'b011);
        check("pass_reg_alu", bus.AluResult, 16'h0042);

        // Asynchronous clear mid-cycle, with outputs holding nonzero values.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_alu", bus.AluResult, 16'h0000);
        check("async_rst_dm", bus.DataMemory, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_hold_alu", bus.AluResult, 16'h0000);
        check("rst_hold_dm", bus.DataMemory, 16'h0000);

        step(16'h0005, 16'h0003, 16'h0000, 3'b001);
        // rst_n still low across this edge: nothing may be captured
        check("rst_edge_alu", bus.AluResult, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_alu", bus.AluResult, 16'h0008);
        check("post_rst_dm", bus.DataMemory, 16'h0003);

        // Back-to-back vectors, inputs change every cycle.
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vi[i] = 16'($urandom);
            vs[i] = 3'(i);
        end
        prev_res = bus.AluResult;
        prev_dm  = bus.DataMemory;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(va[i], vb[i], vi[i], vs[i]);
            #1;
            check("b2b_hold_alu", bus.AluResult, prev_res);
            check("b2b_hold_dm", bus.DataMemory, prev_dm);
            @(posedge clk);
            #1;
            prev_res = ref_result(va[i], vb[i], vi[i], vs[i]);
            prev_dm  = vb[i];
            check("b2b_alu", bus.AluResult, prev_res);
            check("b2b_dm", bus.DataMemory, prev_dm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
